// File: rtl/iir_filter_pkg.sv
// Shared constants and FSM encoding for the first-order IIR low-pass filter.
package iir_filter_pkg;

  localparam int unsigned DW         = 16;
  localparam int unsigned CW         = 8;
  localparam int unsigned ACC_W      = DW + CW + 1;
  localparam int unsigned FRAC_SHIFT = 8;
  localparam logic [DW-1:0] SAT_MAX  = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/iir_filter_shift_add_mac.sv
// Dual-operand serial shift-add MAC: acc = a*x + b*y, one coefficient bit per clk.
module iir_shift_add_mac #(
  parameter int unsigned DW = 16,
  parameter int unsigned CW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DW-1:0]   x,
  input  logic [DW-1:0]   y,
  input  logic [CW-1:0]   a,
  input  logic [CW-1:0]   b,
  output logic [DW+CW:0]  acc,
  output logic            done
);
  import iir_filter_pkg::*;

  localparam int unsigned AW = DW + CW + 1;
  localparam int unsigned IW = $clog2(CW);

  logic [AW-1:0] xs_q, xs_d, ys_q, ys_d, acc_q, acc_d;
  logic [CW-1:0] as_q, as_d, bs_q, bs_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          run_q, run_d;

  // High during the cycle whose closing edge performs the last (MSB) add.
  assign done = run_q && (idx_q == IW'(CW - 1));
  assign acc  = acc_q;

  always_comb begin
    xs_d  = xs_q;
    ys_d  = ys_q;
    as_d  = as_q;
    bs_d  = bs_q;
    acc_d = acc_q;
    idx_d = idx_q;
    run_d = run_q;
    if (start) begin
      xs_d  = AW'(x);
      ys_d  = AW'(y);
      as_d  = a;
      bs_d  = b;
      acc_d = '0;
      idx_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      acc_d = acc_q + (as_q[0] ? xs_q : '0) + (bs_q[0] ? ys_q : '0);
      xs_d  = xs_q << 1;
      ys_d  = ys_q << 1;
      as_d  = as_q >> 1;
      bs_d  = bs_q >> 1;
      idx_d = idx_q + 1'b1;
      if (done) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xs_q  <= '0;
      ys_q  <= '0;
      as_q  <= '0;
      bs_q  <= '0;
      acc_q <= '0;
      idx_q <= '0;
      run_q <= 1'b0;
    end else begin
      xs_q  <= xs_d;
      ys_q  <= ys_d;
      as_q  <= as_d;
      bs_q  <= bs_d;
      acc_q <= acc_d;
      idx_q <= idx_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/iir_filter.sv
// First-order IIR low-pass: y[n] = (a*x[n] + b*y[n-1]) >> 8, one sample per clk_slow rise.
// Define FILTER_ROUND_EN for round-half-up instead of truncation before the shift.
module iir_filter #(
  parameter int unsigned DW = 16,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_slow,
  input  logic [DW-1:0] din,
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  output logic [DW-1:0] dout
);
  import iir_filter_pkg::*;

  localparam int unsigned AW = DW + CW + 1;
  localparam int unsigned RW = AW - FRAC_SHIFT;

  state_e          state_q, state_d;
  logic            clk_slow_q;
  logic            tick;
  logic [DW-1:0]   y_prev_q, y_prev_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic            mac_start;
  logic            mac_done;
  logic [AW-1:0]   mac_acc;
  logic [AW-1:0]   acc_rnd;
  logic [RW-1:0]   res;

  // History resets high so a strobe already high at reset release is not a sample.
  assign tick = clk_slow & ~clk_slow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_slow_q <= 1'b1;
    end else begin
      clk_slow_q <= clk_slow;
    end
  end

  iir_shift_add_mac #(
    .DW(DW),
    .CW(CW)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .start (mac_start),
    .x     (din),
    .y     (y_prev_q),
    .a     (a),
    .b     (b),
    .acc   (mac_acc),
    .done  (mac_done)
  );

`ifdef FILTER_ROUND_EN
  assign acc_rnd = mac_acc + (AW'(1) << (FRAC_SHIFT - 1));
`else
  assign acc_rnd = mac_acc;
`endif

  assign res = acc_rnd[AW-1:FRAC_SHIFT];

  always_comb begin
    state_d   = state_q;
    y_prev_d  = y_prev_q;
    dout_d    = dout_q;
    mac_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          mac_start = 1'b1;
          state_d   = ITER;
        end
      end
      ITER: begin
        if (mac_done) begin
          state_d = OUT;
        end
      end
      OUT: begin
        dout_d   = (|res[RW-1:DW]) ? '1 : res[DW-1:0];
        y_prev_d = dout_d;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      y_prev_q <= '0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      y_prev_q <= y_prev_d;
      dout_q   <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_iir_filter.sv
// Scoreboard bench for iir_filter: expected outputs queued at each strobe, popped at the output edge.
module tb_iir_filter;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        clk_slow = 1'b0;
  logic [15:0] din      = '0;
  logic [7:0]  a        = '0;
  logic [7:0]  b        = '0;
  logic [15:0] dout;

  int tests = 0;
  int fails = 0;

  logic [15:0] sb[$];
  logic [15:0] cur     = '0;
  logic [15:0] y_model = '0;

  iir_filter #(
    .DW(16),
    .CW(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clk_slow (clk_slow),
    .din      (din),
    .a        (a),
    .b        (b),
    .dout     (dout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic [7:0] ca, input logic [7:0] cb);
    longint unsigned s;
    s = 64'(ca) * 64'(x) + 64'(cb) * 64'(y);
`ifdef FILTER_ROUND_EN
    s = s + 64'd128;
`endif
    s = s >> 8;
    return (s > 64'd65535) ? 16'hFFFF : s[15:0];
  endfunction

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    rst      = 1'b1;
    clk_slow = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cur     = '0;
    y_model = '0;
    sb.delete();
  endtask

  // Strobe goes high before edge 0 (the detecting edge); the new value must appear at edge 9.
  // With drop set, inputs are scrambled mid-flight and a second strobe lands at edge 5.
  task automatic sample(input logic [15:0] x, input logic [7:0] ca, input logic [7:0] cb,
                        input bit drop, output logic [15:0] got);
    int          hold_bad = 0;
    logic [15:0] exp_v;
    got = '0;
    @(negedge clk);
    din      = x;
    a        = ca;
    b        = cb;
    clk_slow = 1'b1;
    sb.push_back(model(x, y_model, ca, cb));
    for (int j = 0; j < 16; j++) begin
      @(posedge clk);
      #1;
      if (j == 9) begin
        exp_v = sb.pop_front();
        tests++;
        if (dout !== exp_v) begin
          fails++;
          $display("FAIL sample_value: dout=%0d expected=%0d (x=%0d a=%0d b=%0d)",
                   dout, exp_v, x, ca, cb);
        end
        cur     = exp_v;
        y_model = exp_v;
        got     = dout;
      end else if (dout !== cur) begin
        hold_bad++;
      end
      @(negedge clk);
      if (drop && j == 1) begin
        din = 16'($urandom);
        a   = 8'($urandom);
        b   = 8'($urandom);
      end
      if (drop && j == 2) clk_slow = 1'b0;
      if (drop && j == 4) clk_slow = 1'b1;
      if (j == 7) clk_slow = 1'b0;
    end
    tests++;
    if (hold_bad != 0) begin
      fails++;
      $display("FAIL sample_hold: dout left %0d on %0d edges outside update edge 9 (x=%0d)",
               cur, hold_bad, x);
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    @(negedge clk);
    rst      = 1'b1;
    clk_slow = 1'b1;
    din      = 16'hFFFF;
    a        = 8'd101;
    b        = 8'd154;
    repeat (3) @(negedge clk);
    tests++;
    if (dout !== 16'h0000) begin
      fails++;
      $display("FAIL reset_value: dout=%0h expected=0000", dout);
    end
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (dout !== 16'h0000) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL reset_strobe_high: dout nonzero on %0d edges, expected 0", bad);
    end
    @(negedge clk);
    clk_slow = 1'b0;
    @(negedge clk);
    cur     = '0;
    y_model = '0;
  endtask

  task automatic test_idle_zero();
    logic [15:0] got;
    for (int n = 0; n < 3; n++) sample(16'h0000, 8'd101, 8'd154, 1'b0, got);
  endtask

  task automatic test_step_up();
    logic [15:0] got;
    logic [15:0] prev = '0;
    int          mono_bad = 0;
    for (int n = 0; n < 30; n++) begin
      sample(16'hFFFF, 8'd101, 8'd154, 1'b0, got);
`ifndef FILTER_ROUND_EN
      if (n == 0) begin
        tests++;
        if (got !== 16'd25855) begin
          fails++;
          $display("FAIL step_first: dout=%0d expected=25855", got);
        end
      end
      if (n == 1) begin
        tests++;
        if (got !== 16'd41409) begin
          fails++;
          $display("FAIL step_second: dout=%0d expected=41409", got);
        end
      end
`endif
      if (got < prev) mono_bad++;
      prev = got;
    end
    tests++;
    if (mono_bad != 0) begin
      fails++;
      $display("FAIL step_monotonic: %0d decreasing steps, expected 0", mono_bad);
    end
`ifndef FILTER_ROUND_EN
    tests++;
    if (prev < 16'd64885 || prev > 16'd64892) begin
      fails++;
      $display("FAIL step_settle: dout=%0d expected 64885..64892", prev);
    end
`endif
  endtask

  task automatic test_step_down();
    logic [15:0] got = '0;
    for (int n = 0; n < 30; n++) sample(16'h0000, 8'd101, 8'd154, 1'b0, got);
`ifndef FILTER_ROUND_EN
    tests++;
    if (got !== 16'h0000) begin
      fails++;
      $display("FAIL stepdown_zero: dout=%0d expected=0", got);
    end
`endif
  endtask

  task automatic test_latency_drop();
    logic [15:0] got;
    sample(16'hFFFF, 8'd101, 8'd154, 1'b1, got);
    sample(16'h8000, 8'd60, 8'd190, 1'b0, got);
    sample(16'h1234, 8'd128, 8'd127, 1'b1, got);
  endtask

  task automatic test_reset_midop();
    logic [15:0] got;
    int          bad = 0;
    @(negedge clk);
    din      = 16'hFFFF;
    a        = 8'd101;
    b        = 8'd154;
    clk_slow = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst      = 1'b1;
    clk_slow = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (dout !== 16'h0000) begin
      fails++;
      $display("FAIL midop_reset: dout=%0d expected=0", dout);
    end
    @(negedge clk);
    rst     = 1'b0;
    cur     = '0;
    y_model = '0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (dout !== 16'h0000) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL midop_aborted: dout nonzero on %0d edges after abort, expected 0", bad);
    end
    sample(16'hFFFF, 8'd101, 8'd154, 1'b0, got);
    tests++;
`ifdef FILTER_ROUND_EN
    if (got !== 16'd25856) begin
      fails++;
      $display("FAIL midop_restart: dout=%0d expected=25856", got);
    end
`else
    if (got !== 16'd25855) begin
      fails++;
      $display("FAIL midop_restart: dout=%0d expected=25855", got);
    end
`endif
  endtask

  task automatic test_saturation();
    logic [15:0] got;
    apply_reset(2);
    // 255*65535 >> 8 = 65279 on the first sample, then the feedback term overflows.
    sample(16'hFFFF, 8'd255, 8'd255, 1'b0, got);
    sample(16'hFFFF, 8'd255, 8'd255, 1'b0, got);
    tests++;
    if (got !== 16'hFFFF) begin
      fails++;
      $display("FAIL sat_clamp: dout=%0h expected=ffff", got);
    end
  endtask

  initial begin
    test_reset();
    test_idle_zero();
    test_step_up();
    test_step_down();
    test_latency_drop();
    test_reset_midop();
    test_saturation();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
